// File: rtl/updn_ctr_pkg.sv
// Shared types and constants for the up/down counter sweep sequencer.
package updn_ctr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned NUM_REQ    = 2;
  localparam int unsigned STATUS_W   = 2;

  localparam logic [STATUS_W-1:0] ST_OK      = 2'b00;
  localparam logic [STATUS_W-1:0] ST_ABORT   = 2'b01;
  localparam logic [STATUS_W-1:0] ST_TIMEOUT = 2'b10;

  // Select one requester's field from a 2-way packed vector.
  function automatic logic [31:0] pick_field(input logic [63:0] packed_v,
                                             input logic        id,
                                             input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return id ? 32'((packed_v >> w) & 64'(mask)) : 32'(packed_v & 64'(mask));
  endfunction

endpackage

// File: rtl/updn_ctr_seq_arb.sv
// Two-way round-robin arbiter; pointer moves past the winner on accept.
module updn_rr_arb2
  import updn_ctr_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   valid,
  input  logic                 accept,
  output logic [NUM_REQ-1:0]   grant_c,
  output logic                 grant_id_c
);

  logic ptr_q;

  // Contested requests follow the pointer, a lone request always wins.
  always_comb begin
    grant_c    = '0;
    grant_id_c = 1'b0;
    if (valid == 2'b11) begin
      grant_id_c = ptr_q;
    end else begin
      grant_id_c = valid[1];
    end
    if (valid != 2'b00) begin
      grant_c = grant_id_c ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else if (accept) begin
      ptr_q <= ~grant_id_c;
    end
  end

endmodule

// File: rtl/updn_ctr_seq.sv
// Sequencer/arbiter sharing one external up/down counter between two requesters.
// Optional `UPDN_SEQ_WRAP_FLAG_EN adds done_wrapped (sweep crossed all-ones going up).
module updn_ctr_seq
  import updn_ctr_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned TO_SLACK = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_start,
  input  logic [2*WIDTH-1:0]   req_target,
  input  logic [1:0]           req_up,
  input  logic                 abort,
  output logic [WIDTH-1:0]     ctr_data,
  output logic                 ctr_load,
  output logic                 ctr_cen,
  output logic                 ctr_up_dn,
  input  logic [WIDTH-1:0]     ctr_count,
  input  logic                 ctr_tercnt,
  output logic                 busy,
  output logic                 done,
  output logic                 done_id,
  output logic [1:0]           done_status,
  output logic                 err
`ifdef UPDN_SEQ_WRAP_FLAG_EN
  ,
  output logic                 done_wrapped
`endif
);

  localparam int unsigned TW = WIDTH + 2;
  // Last RUN cycle index before a sweep is declared stuck.
  localparam logic [TW-1:0] TO_LAST = TW'((2 ** WIDTH) + TO_SLACK - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     start_q, target_q;
  logic                 up_q, id_q;
  logic [TW-1:0]        run_cnt_q;
  logic                 ctr_load_q, busy_q;
  logic                 done_q, done_id_q, err_q;
  logic [STATUS_W-1:0]  status_q;

  logic [1:0]           arb_valid;
  logic [1:0]           grant;
  logic                 grant_id;
  logic                 handshake;
  logic                 match;
  logic                 done_set;
  logic                 to_hit;
  logic [STATUS_W-1:0]  status_d;
  logic [WIDTH-1:0]     sel_start, sel_target;

  assign arb_valid = (state_q == IDLE) ? req_valid : 2'b00;
  assign handshake = |(req_valid & grant);
  assign req_ready = grant;
  assign match     = (ctr_count == target_q);

  assign sel_start  = grant_id ? req_start[2*WIDTH-1:WIDTH]  : req_start[WIDTH-1:0];
  assign sel_target = grant_id ? req_target[2*WIDTH-1:WIDTH] : req_target[WIDTH-1:0];

  updn_rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .valid      (arb_valid),
    .accept     (handshake),
    .grant_c    (grant),
    .grant_id_c (grant_id)
  );

  // Next state, completion status and combinational count enable.
  always_comb begin
    state_d  = state_q;
    done_set = 1'b0;
    to_hit   = 1'b0;
    status_d = ST_OK;
    ctr_cen  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (handshake) state_d = LOAD;
      end
      LOAD: begin
        state_d = RUN;
        if (abort) begin
          state_d  = DONE;
          done_set = 1'b1;
          status_d = ST_ABORT;
        end
      end
      RUN: begin
        if (abort) begin
          state_d  = DONE;
          done_set = 1'b1;
          status_d = ST_ABORT;
        end else if (match) begin
          state_d  = DONE;
          done_set = 1'b1;
          status_d = ST_OK;
        end else if (run_cnt_q == TO_LAST) begin
          state_d  = DONE;
          done_set = 1'b1;
          to_hit   = 1'b1;
          status_d = ST_TIMEOUT;
        end else begin
          ctr_cen = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      start_q    <= '0;
      target_q   <= '0;
      up_q       <= 1'b0;
      id_q       <= 1'b0;
      run_cnt_q  <= '0;
      ctr_load_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= 1'b0;
      status_q   <= ST_OK;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctr_load_q <= (state_d == LOAD);
      busy_q     <= (state_d != IDLE);
      done_q     <= done_set;
      done_id_q  <= done_set ? id_q : 1'b0;
      status_q   <= done_set ? status_d : ST_OK;
      err_q      <= err_q | to_hit;
      if (handshake) begin
        start_q  <= sel_start;
        target_q <= sel_target;
        up_q     <= grant_id ? req_up[1] : req_up[0];
        id_q     <= grant_id;
      end
      if (state_q == LOAD) begin
        run_cnt_q <= '0;
      end else if (state_q == RUN) begin
        run_cnt_q <= run_cnt_q + TW'(1);
      end
    end
  end

  assign ctr_data    = start_q;
  assign ctr_load    = ctr_load_q;
  assign ctr_up_dn   = up_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign done_id     = done_id_q;
  assign done_status = status_q;
  assign err         = err_q;

`ifdef UPDN_SEQ_WRAP_FLAG_EN
  logic wrap_q, wrap_set, done_wrapped_q;

  // An enabled up-step while all-ones means the counter rolled over to zero.
  assign wrap_set = (state_q == RUN) & ctr_cen & up_q & ctr_tercnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_q         <= 1'b0;
      done_wrapped_q <= 1'b0;
    end else begin
      if (handshake) begin
        wrap_q <= 1'b0;
      end else if (wrap_set) begin
        wrap_q <= 1'b1;
      end
      done_wrapped_q <= done_set ? (wrap_q | wrap_set) : 1'b0;
    end
  end

  assign done_wrapped = done_wrapped_q;
`else
  logic unused_tercnt;
  assign unused_tercnt = ctr_tercnt;
`endif

endmodule
